// File: rtl/fc_mac_layer.sv
// Fully connected MAC layer. Activations stream in one per beat, and each
// beat is multiplied against one stored weight row. The per-neuron sums are
// presented as one result vector once IN beats have been accepted.
module fc_mac_layer #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT   = 84
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clr,
    input  logic                                    relu_en,
    input  logic                                    w_we,
    input  logic [$clog2(IN)-1:0]                   w_addr,
    input  logic [OUT*WIDTH-1:0]                    w_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [WIDTH-1:0]                        s_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [OUT*(2*WIDTH+$clog2(IN))-1:0]     m_data
);

    localparam int ACC_W = 2*WIDTH + $clog2(IN);
    localparam int AW    = $clog2(IN);
    localparam int PW    = 2*WIDTH;
    localparam logic [AW:0]   IN_L     = (AW+1)'(IN);
    localparam logic [AW-1:0] LAST_IDX = AW'(IN-1);

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t                  state_q;
    logic [AW-1:0]           idx_q;
    logic signed [ACC_W-1:0] acc_q [OUT];
    logic [OUT*WIDTH-1:0]    w_q [IN];
    logic                    s_ready_q;
    logic                    m_valid_q;
    logic [OUT*ACC_W-1:0]    m_data_q;

    logic [OUT*WIDTH-1:0]    w_row_s;
    logic signed [ACC_W-1:0] sum_s [OUT];
    logic [OUT*ACC_W-1:0]    res_s;
    logic                    beat_s;
    logic                    last_s;
    logic                    hs_s;
    logic                    w_ok_s;

    // Full-precision signed product, sign-extended to accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        logic signed [PW-1:0] p;
        ae = {{WIDTH{a[WIDTH-1]}}, a};
        be = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ae * be;
        return {{(ACC_W-PW){p[PW-1]}}, p};
    endfunction

    // Optional rectification of a finished sum.
    function automatic logic signed [ACC_W-1:0] relu_f(
        input logic signed [ACC_W-1:0] v,
        input logic                    en
    );
        logic signed [ACC_W-1:0] r;
        if (en && v[ACC_W-1]) begin
            r = {ACC_W{1'b0}};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Handshake decode, weight row fetch and next sums for the current beat.
    always_comb begin
        w_row_s = w_q[idx_q];
        beat_s  = s_valid & s_ready_q;
        last_s  = (idx_q == LAST_IDX);
        hs_s    = m_valid_q & m_ready;
        w_ok_s  = ({1'b0, w_addr} < IN_L);
        res_s   = {(OUT*ACC_W){1'b0}};
        for (int n = 0; n < OUT; n++) begin
            sum_s[n] = acc_q[n] + mul_ext_f(s_data, w_row_s[n*WIDTH +: WIDTH]);
            res_s[n*ACC_W +: ACC_W] = relu_f(sum_s[n], relu_en);
        end
    end

    // Weight register file. A beat reading this row in the same cycle sees the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < IN; k++) begin
                w_q[k] <= {(OUT*WIDTH){1'b0}};
            end
        end else if (w_we && w_ok_s) begin
            w_q[w_addr] <= w_data;
        end
    end

    // Frame FSM: accumulate IN beats, then hold the result until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_ACC;
            idx_q     <= {AW{1'b0}};
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= {(OUT*ACC_W){1'b0}};
            for (int n = 0; n < OUT; n++) begin
                acc_q[n] <= {ACC_W{1'b0}};
            end
        end else if (clr) begin
            state_q   <= S_ACC;
            idx_q     <= {AW{1'b0}};
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            for (int n = 0; n < OUT; n++) begin
                acc_q[n] <= {ACC_W{1'b0}};
            end
        end else begin
            case (state_q)
                S_ACC: begin
                    if (beat_s && last_s) begin
                        state_q   <= S_OUT;
                        s_ready_q <= 1'b0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= res_s;
                    end else if (beat_s) begin
                        idx_q     <= idx_q + AW'(1'b1);
                        s_ready_q <= 1'b1;
                        for (int n = 0; n < OUT; n++) begin
                            acc_q[n] <= sum_s[n];
                        end
                    end else begin
                        s_ready_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (hs_s) begin
                        state_q   <= S_ACC;
                        idx_q     <= {AW{1'b0}};
                        s_ready_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        for (int n = 0; n < OUT; n++) begin
                            acc_q[n] <= {ACC_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_q   <= S_ACC;
                    idx_q     <= {AW{1'b0}};
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_fc_mac_layer.sv
// Testbench for fc_mac_layer (WIDTH=8, IN=4, OUT=2): directed frames with
// hand-computed results plus randomized traffic checked every cycle against
// an integer reference model.
module tb_fc_mac_layer;

    localparam int WIDTH = 8;
    localparam int IN    = 4;
    localparam int OUT   = 2;
    localparam int ACC_W = 18;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              relu_en;
    logic              w_we;
    logic [1:0]        w_addr;
    logic [15:0]       w_data;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              m_valid;
    logic              m_ready;
    logic [35:0]       m_data;

    fc_mac_layer #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .relu_en (relu_en),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int prints   = 0;

    // reference model state
    int wm [IN][OUT];
    int macc [OUT];
    int nb      = 0;
    bit e_ready = 1'b0;
    bit e_pend  = 1'b0;
    int e_res [OUT];
    int nframes = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
            end
        end
    endtask

    function automatic int nres(input int n);
        return int'($signed(m_data[n*ACC_W +: ACC_W]));
    endfunction

    // Reference model: frame-level arithmetic on integers.
    initial begin
        for (int k = 0; k < IN; k++)
            for (int n = 0; n < OUT; n++) wm[k][n] = 0;
        for (int n = 0; n < OUT; n++) begin macc[n] = 0; e_res[n] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < IN; k++)
                    for (int n = 0; n < OUT; n++) wm[k][n] = 0;
                for (int n = 0; n < OUT; n++) macc[n] = 0;
                nb = 0; e_ready = 1'b0; e_pend = 1'b0;
            end else begin
                if (clr) begin
                    for (int n = 0; n < OUT; n++) macc[n] = 0;
                    nb = 0; e_pend = 1'b0; e_ready = 1'b1;
                end else if (e_pend) begin
                    if (m_ready) begin
                        for (int n = 0; n < OUT; n++) macc[n] = 0;
                        nb = 0; e_pend = 1'b0; e_ready = 1'b1;
                    end
                end else if (e_ready && s_valid) begin
                    for (int n = 0; n < OUT; n++)
                        macc[n] = macc[n] + int'($signed(s_data)) * wm[nb][n];
                    nb++;
                    if (nb == IN) begin
                        for (int n = 0; n < OUT; n++)
                            e_res[n] = (relu_en && macc[n] < 0) ? 0 : macc[n];
                        e_pend = 1'b1; e_ready = 1'b0; nframes++;
                    end
                end else begin
                    e_ready = 1'b1;
                end
                if (w_we && int'(w_addr) < IN)
                    for (int n = 0; n < OUT; n++)
                        wm[w_addr][n] = int'($signed(w_data[n*WIDTH +: WIDTH]));
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("s_ready", int'(s_ready), int'(e_ready));
            chk("m_valid", int'(m_valid), int'(e_pend));
            if (e_pend)
                for (int n = 0; n < OUT; n++) chk("m_data", nres(n), e_res[n]);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_all(input int w0, input int w1);
        for (int k = 0; k < IN; k++) begin
            w_we = 1'b1; w_addr = 2'(k); w_data = {8'(w1), 8'(w0)};
            cyc();
        end
        w_we = 1'b0;
    endtask

    task automatic frame4(input int a0, input int a1, input int a2, input int a3);
        s_valid = 1'b1;
        s_data = 8'(a0); cyc();
        s_data = 8'(a1); cyc();
        s_data = 8'(a2); cyc();
        s_data = 8'(a3); cyc();
        s_valid = 1'b0;
    endtask

    task automatic consume();
        m_ready = 1'b1; cyc(); m_ready = 1'b0;
        chk("bubble_s_ready", int'(s_ready), 1);
        chk("bubble_m_valid", int'(m_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; relu_en = 1'b0; w_we = 1'b0; w_addr = 2'd0;
        w_data = 16'd0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("reset_s_ready", int'(s_ready), 0);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_data", nres(0), 0);
        cyc();
        chk("post_reset_s_ready", int'(s_ready), 1);

        // basic frame, ReLU on and off
        set_all(1, -1);
        relu_en = 1'b1;
        frame4(1, 2, 3, 4);
        chk("basic_latency", int'(m_valid), 1);
        chk("basic_n0", nres(0), 10);
        chk("basic_n1_relu", nres(1), 0);
        consume();
        relu_en = 1'b0;
        frame4(1, 2, 3, 4);
        chk("basic_n1_signed", nres(1), -10);
        consume();

        // extreme operands
        set_all(-128, -128);
        frame4(-128, -128, -128, -128);
        chk("ext_pos_n0", nres(0), 65536);
        chk("ext_pos_n1", nres(1), 65536);
        consume();
        frame4(127, 127, 127, 127);
        chk("ext_neg_n0", nres(0), -65024);

        // backpressure with ignored beats
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'($urandom); cyc();
            chk("bp_s_ready", int'(s_ready), 0);
            chk("bp_hold", nres(1), -65024);
        end
        s_valid = 1'b0;
        consume();
        frame4(1, 2, 3, 4);
        chk("bp_next_n0", nres(0), -1280);
        consume();

        // frame abort
        set_all(1, -1);
        s_valid = 1'b1; s_data = 8'd5; cyc();
        s_data = 8'd6; cyc();
        s_data = 8'd7; clr = 1'b1; cyc();
        clr = 1'b0; s_valid = 1'b0;
        chk("clr_m_valid", int'(m_valid), 0);
        chk("clr_s_ready", int'(s_ready), 1);
        frame4(1, 2, 3, 4);
        chk("clr_n0", nres(0), 10);
        chk("clr_n1", nres(1), -10);
        consume();

        // weight write on the same row as the beat
        s_valid = 1'b1; s_data = 8'd1; cyc();
        s_data = 8'd2; cyc();
        s_data = 8'd3; w_we = 1'b1; w_addr = 2'd2; w_data = {8'd10, 8'd10}; cyc();
        w_we = 1'b0; s_data = 8'd4; cyc();
        s_valid = 1'b0;
        chk("wr_old_n0", nres(0), 10);
        chk("wr_old_n1", nres(1), -10);
        consume();
        frame4(1, 2, 3, 4);
        chk("wr_new_n0", nres(0), 37);
        chk("wr_new_n1", nres(1), 23);

        // reset while a result is pending
        rst_n = 1'b0;
        #1;
        chk("rst_out_m_valid", int'(m_valid), 0);
        chk("rst_out_s_ready", int'(s_ready), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        frame4(1, 2, 3, 4);
        chk("rst_zero_n0", nres(0), 0);
        chk("rst_zero_n1", nres(1), 0);
        consume();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 2) == 0);
            w_we    = ($urandom_range(0, 7) == 0);
            w_addr  = 2'($urandom);
            w_data  = 16'($urandom);
            relu_en = 1'($urandom);
            clr     = ($urandom_range(0, 99) == 0);
            cyc();
        end
        s_valid = 1'b0; w_we = 1'b0; clr = 1'b0; m_ready = 1'b1;
        cyc(); cyc();
        chk("random_frames_seen", int'(nframes > 50), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_mac_layer.md
FC_MAC_LAYER -- requirements
Module: fc_mac_layer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: activation and weight width, signed two's complement.
REQ-002 SHALL have parameter IN, default 128: number of input activations per frame, minimum 2.
REQ-003 SHALL have parameter OUT, default 84: number of neurons computed in parallel.
REQ-004 SHALL have localparam ACC_W = 2*WIDTH + $clog2(IN): accumulator and result width per neuron.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous frame abort.
- relu_en  in  1  1 = apply ReLU to results, 0 = pass signed sums.
- w_we  in  1  weight row write enable.
- w_addr  in  $clog2(IN)  weight row index (input position).
- w_data  in  OUT*WIDTH  weights for all neurons at that row; neuron n at bits [n*WIDTH +: WIDTH].
- s_valid  in  1  activation valid.
- s_ready  out  1  activation accepted when s_valid & s_ready.
- s_data  in  WIDTH  signed activation.
- m_valid  out  1  result vector valid.
- m_ready  in  1  result consumed when m_valid & m_ready.
- m_data  out  OUT*ACC_W  results; neuron n at bits [n*ACC_W +: ACC_W].

Function
REQ-006 SHALL hold an IN x (OUT*WIDTH) weight register file; a write at rising edge with w_we=1 and w_addr<IN SHALL be visible from the next cycle; writes with w_addr>=IN SHALL be ignored.
REQ-007 SHALL implement FSM states ACC and OUT; reset state is ACC.
REQ-008 In ACC: s_ready=1 and m_valid=0; each accepted beat SHALL add sign-extended s_data*W[idx][n] into accumulator n for every n, where idx is the beat counter, then increment idx.
REQ-009 A weight write and a beat reading the same row in the same cycle SHALL use the old weight.
REQ-010 The beat with idx=IN-1 SHALL transition to OUT; m_data SHALL be registered from the final sums; m_valid=1 on the cycle after that beat (latency 1).
REQ-011 In OUT: s_ready=0, m_valid=1, and m_data SHALL be held stable until m_valid & m_ready.
REQ-012 On m_valid & m_ready: SHALL return to ACC next cycle with accumulators and idx cleared; s_ready SHALL be 1 that cycle, so there is one bubble cycle between frames.
REQ-013 Result per neuron SHALL be relu_en ? (sum<0 ? 0 : sum) : sum, with relu_en sampled when the final beat is accepted.
REQ-014 Arithmetic SHALL be signed, full precision and never saturate; ACC_W is sufficient for IN products of extreme operands.
REQ-015 clr=1 SHALL clear the accumulators and idx, drop m_valid and enter ACC next cycle, and SHALL take priority over a simultaneous beat or handshake; weights are unaffected.
REQ-016 s_valid while s_ready=0 SHALL have no effect; s_data need not be held.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state=ACC, idx=0, all accumulators=0, m_data=0, m_valid=0, and all weights=0.
REQ-018 s_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after deassertion.
REQ-019 Reset asserted mid-frame or in OUT SHALL discard the partial or pending result with no output handshake.

Verification (WIDTH=8, IN=4, OUT=2)
REQ-020 Load rows W[k]={n0:1, n1:-1} for all k, stream 1,2,3,4, relu_en=1 -> one cycle after the last beat, m_valid=1, n0=10, n1=0; with relu_en=0, n1=-10.
REQ-021 Extreme operands: all weights -128, activations -128 x4 -> each neuron = 65536, no wrap; all weights -128, activations 127 x4 with relu_en=0 -> -65024.
REQ-022 Backpressure: hold m_ready=0 for 5 cycles -> m_data stable, s_ready=0, extra s_valid beats ignored; next frame result is correct.
REQ-023 Assert clr after 2 beats -> no m_valid; a subsequent 4-beat frame yields only its own sum.
REQ-024 Write row 2 in the same cycle beat 2 is accepted -> the sum uses the old weight; the next frame uses the new weight.
REQ-025 Assert rst_n low in OUT -> m_valid=0 immediately, weights read 0, and a new frame sums to 0.
